frame_buffer_axi4_wr_slave: RTL

AXI4 write-only slave that terminates the pixel-transfer master port (s_aw*/s_w*/s_b*) of the DVP RX controller. It accepts INCR bursts of packed grayscale pixel words and writes them into a single-port frame SRAM through a simple registered write port. It returns one B response per burst and pulses a frame-complete strobe once a full frame of words has been written.

---
 rtl/frame_buffer_axi4_wr_slave.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/frame_buffer_axi4_wr_slave.sv
// AXI4 write-only slave that lands INCR bursts of packed pixel words in a frame SRAM
// and pulses frame_done_o once a full frame of words has been written.
module frame_buffer_axi4_wr_slave #(
    parameter int unsigned         DATA_W            = 32,
    parameter int unsigned         ADDR_W            = 32,
    parameter int unsigned         MST_ID_W          = 5,
    parameter int unsigned         TRANS_DATA_LEN_W  = 8,
    parameter int unsigned         TRANS_DATA_SIZE_W = 3,
    parameter int unsigned         TRANS_RESP_W      = 2,
    parameter logic [ADDR_W-1:0]   BASE_ADDR         = ADDR_W'(32'h2000_0000),
    parameter int unsigned         MEM_ADDR_W        = 16,
    parameter int unsigned         FRAME_WORDS       = 19200
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [MST_ID_W-1:0]          s_awid_i,
    input  logic [ADDR_W-1:0]            s_awaddr_i,
    input  logic [TRANS_DATA_LEN_W-1:0]  s_awlen_i,
    input  logic [TRANS_DATA_SIZE_W-1:0] s_awsize_i,
    input  logic                         s_awvalid_i,
    output logic                         s_awready_o,
    input  logic [DATA_W-1:0]            s_wdata_i,
    input  logic                         s_wvalid_i,
    output logic                         s_wready_o,
    output logic [MST_ID_W-1:0]          s_bid_o,
    output logic [TRANS_RESP_W-1:0]      s_bresp_o,
    output logic                         s_bvalid_o,
    input  logic                         s_bready_i,
    output logic                         mem_wr_en_o,
    output logic [MEM_ADDR_W-1:0]        mem_wr_addr_o,
    output logic [DATA_W-1:0]            mem_wr_data_o,
    output logic                         frame_done_o
);

    localparam int unsigned SIZE_LOG2 = $clog2(DATA_W / 8);
    localparam int unsigned FCNT_W    = MEM_ADDR_W + 1;
    localparam logic [FCNT_W-1:0]       FRAME_LAST  = FCNT_W'(FRAME_WORDS - 1);
    localparam logic [ADDR_W-1:0]       ALIGN_MASK  = ADDR_W'((1 << SIZE_LOG2) - 1);
    localparam logic [TRANS_RESP_W-1:0] RESP_OKAY   = '0;
    localparam logic [TRANS_RESP_W-1:0] RESP_SLVERR = TRANS_RESP_W'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                        r_state;
    logic [MST_ID_W-1:0]           r_id;
    logic [TRANS_DATA_LEN_W-1:0]   r_len;
    logic [TRANS_DATA_LEN_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]             r_ptr;
    logic                          r_err;
    logic [FCNT_W-1:0]             r_fcnt;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic [ADDR_W-1:0] w_offset;
    logic [ADDR_W-1:0] w_start_word;
    logic              w_aw_err;
    logic              w_in_range;
    logic              w_wr_ok;
    logic              w_last;

    assign w_aw_hs      = s_awvalid_i & s_awready_o;
    assign w_w_hs       = s_wvalid_i & s_wready_o;
    assign w_b_hs       = s_bvalid_o & s_bready_i;
    assign w_offset     = s_awaddr_i - BASE_ADDR;
    assign w_start_word = w_offset >> SIZE_LOG2;
    assign w_aw_err     = (s_awsize_i != TRANS_DATA_SIZE_W'(SIZE_LOG2))
                        | (s_awaddr_i < BASE_ADDR)
                        | ((s_awaddr_i & ALIGN_MASK) != '0);
    // Pointer is wider than the SRAM so running off the end is detectable
    assign w_in_range   = (r_ptr >> MEM_ADDR_W) == '0;
    assign w_wr_ok      = ~r_err & w_in_range;
    assign w_last       = (r_cnt == r_len);

    // Burst FSM with registered AXI and SRAM outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_id          <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_ptr         <= '0;
            r_err         <= 1'b0;
            r_fcnt        <= '0;
            s_awready_o   <= 1'b0;
            s_wready_o    <= 1'b0;
            s_bvalid_o    <= 1'b0;
            s_bid_o       <= '0;
            s_bresp_o     <= '0;
            mem_wr_en_o   <= 1'b0;
            mem_wr_addr_o <= '0;
            mem_wr_data_o <= '0;
            frame_done_o  <= 1'b0;
        end else begin
            mem_wr_en_o  <= 1'b0;
            frame_done_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    s_awready_o <= 1'b1;
                    if (w_aw_hs) begin
                        r_id        <= s_awid_i;
                        r_len       <= s_awlen_i;
                        r_cnt       <= '0;
                        r_ptr       <= w_start_word;
                        r_err       <= w_aw_err;
                        s_awready_o <= 1'b0;
                        s_wready_o  <= 1'b1;
                        r_state     <= DATA;
                    end
                end
                DATA: begin
                    if (w_w_hs) begin
                        if (w_wr_ok) begin
                            mem_wr_en_o   <= 1'b1;
                            mem_wr_addr_o <= r_ptr[MEM_ADDR_W-1:0];
                            mem_wr_data_o <= s_wdata_i;
                            // Frame boundary is marked on the write that completes it
                            if (r_fcnt == FRAME_LAST) begin
                                r_fcnt       <= '0;
                                frame_done_o <= 1'b1;
                            end else begin
                                r_fcnt <= r_fcnt + FCNT_W'(1);
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_ptr <= r_ptr + ADDR_W'(1);
                        r_cnt <= r_cnt + TRANS_DATA_LEN_W'(1);
                        if (w_last) begin
                            s_wready_o <= 1'b0;
                            s_bvalid_o <= 1'b1;
                            s_bid_o    <= r_id;
                            s_bresp_o  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                            r_state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (w_b_hs) begin
                        s_bvalid_o  <= 1'b0;
                        s_bid_o     <= '0;
                        s_bresp_o   <= '0;
                        s_awready_o <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
